comp_mag_seq: RTL and testbench

//  Parametrised multi-cycle magnitude comparator. Compares two WIDTH-bit operands

---
 rtl/comp_mag_seq.sv | 135 +++++++++++++
 tb/tb_comp_mag_seq.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/comp_mag_seq.sv
// Multi-cycle magnitude comparator: walks the operands MSB chunk first and stops at the first unequal chunk.
// Optional two's-complement ordering is enabled by defining COMPMAG_SIGNED_EN (adds the signed_mode port).
module comp_mag_seq #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef COMPMAG_SIGNED_EN
    input  logic             signed_mode,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic             aeqb,
    output logic             agtb,
    output logic             altb
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IW-1:0] TOP_IDX = IW'(NCHUNK - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CMP  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             aeqb_q, aeqb_d;
    logic             agtb_q, agtb_d;
    logic             altb_q, altb_d;
    logic [CHUNK-1:0] ca, cb;

`ifdef COMPMAG_SIGNED_EN
    logic sgn_q, sgn_d;
`else
    logic sgn_q;
    assign sgn_q = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        aeqb_d  = aeqb_q;
        agtb_d  = agtb_q;
        altb_d  = altb_q;
`ifdef COMPMAG_SIGNED_EN
        sgn_d   = sgn_q;
`endif
        ca = a_q[idx_q*CHUNK +: CHUNK];
        cb = b_q[idx_q*CHUNK +: CHUNK];
        // Offset-binary: flipping the sign bit makes an unsigned compare order two's-complement values.
        if (sgn_q && (idx_q == TOP_IDX)) begin
            ca[CHUNK-1] = ~ca[CHUNK-1];
            cb[CHUNK-1] = ~cb[CHUNK-1];
        end

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
`ifdef COMPMAG_SIGNED_EN
                    sgn_d   = signed_mode;
`endif
                    idx_d   = TOP_IDX;
                    state_d = S_CMP;
                end
            end
            S_CMP: begin
                if (ca > cb) begin
                    agtb_d  = 1'b1;
                    state_d = S_DONE;
                end else if (ca < cb) begin
                    altb_d  = 1'b1;
                    state_d = S_DONE;
                end else if (idx_q == '0) begin
                    aeqb_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    aeqb_d  = 1'b0;
                    agtb_d  = 1'b0;
                    altb_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            aeqb_q  <= 1'b0;
            agtb_q  <= 1'b0;
            altb_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            aeqb_q  <= aeqb_d;
            agtb_q  <= agtb_d;
            altb_q  <= altb_d;
        end
    end

    // Operand registers carry no reset; they are only read after a fresh accept.
    always_ff @(posedge clk) begin
        a_q <= a_d;
        b_q <= b_d;
`ifdef COMPMAG_SIGNED_EN
        sgn_q <= sgn_d;
`endif
    end

    assign in_ready  = rst_n && (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign aeqb      = aeqb_q;
    assign agtb      = agtb_q;
    assign altb      = altb_q;

endmodule

// File: tb/tb_comp_mag_seq.sv
// Self-checking bench for comp_mag_seq: a 16/4 instance and an 8/1 instance against an arithmetic reference.
module tb_comp_mag_seq;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        iv0, ir0, ov0, or0, eq0, gt0, lt0, sm0;
    logic [15:0] a0, b0;
    logic        iv1, ir1, ov1, or1, eq1, gt1, lt1, sm1;
    logic [7:0]  a1, b1;

    comp_mag_seq #(.WIDTH(16), .CHUNK(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .a(a0), .b(b0),
`ifdef COMPMAG_SIGNED_EN
        .signed_mode(sm0),
`endif
        .out_valid(ov0), .out_ready(or0), .aeqb(eq0), .agtb(gt0), .altb(lt0)
    );

    comp_mag_seq #(.WIDTH(8), .CHUNK(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
`ifdef COMPMAG_SIGNED_EN
        .signed_mode(sm1),
`endif
        .out_valid(ov1), .out_ready(or1), .aeqb(eq1), .agtb(gt1), .altb(lt1)
    );

    int unsigned errors = 0;
    int unsigned checks = 0;
    logic        sel = 1'b0;
    logic        ov_m, ir_m;
    logic [2:0]  fl_m;

    always_comb begin
        ov_m = sel ? ov1 : ov0;
        ir_m = sel ? ir1 : ir0;
        fl_m = sel ? {eq1, gt1, lt1} : {eq0, gt0, lt0};
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer ordering, flags packed {eq, gt, lt}.
    function automatic logic [2:0] ref_res(input logic [15:0] av, input logic [15:0] bv,
                                           input int w, input logic smv);
        longint va = longint'(av);
        longint vb = longint'(bv);
        if (smv && av[w-1]) va -= (longint'(1) << w);
        if (smv && bv[w-1]) vb -= (longint'(1) << w);
        if (va == vb) return 3'b100;
        if (va > vb)  return 3'b010;
        return 3'b001;
    endfunction

    // Chunks examined = chunks from the top down to the one holding the highest differing bit.
    function automatic int ref_lat(input logic [15:0] av, input logic [15:0] bv, input int w, input int c);
        logic [15:0] x = av ^ bv;
        for (int i = w - 1; i >= 0; i--)
            if (x[i]) return (w / c) - (i / c);
        return w / c;
    endfunction

    task automatic drive(input logic v, input logic [15:0] av, input logic [15:0] bv, input logic smv);
        if (sel) begin
            iv1 = v; a1 = av[7:0]; b1 = bv[7:0]; sm1 = smv;
        end else begin
            iv0 = v; a0 = av; b0 = bv; sm0 = smv;
        end
    endtask

    task automatic set_oready(input logic v);
        if (sel) or1 = v; else or0 = v;
    endtask

    // Entered and left at posedge+1 with the selected DUT idle.
    task automatic run(input logic s, input logic [15:0] av, input logic [15:0] bv,
                       input logic smv, input int hold);
        int w = s ? 8 : 16;
        int c = s ? 1 : 4;
        int nmax = w / c;
        int n = 0;
        logic [2:0] exp_f;
        sel = s;
        if (s) begin av[15:8] = '0; bv[15:8] = '0; end
        exp_f = ref_res(av, bv, w, smv);
        chk("in_ready_idle", 32'(ir_m), 32'd1);
        drive(1'b1, av, bv, smv);
        @(posedge clk); #1;
        drive(1'b0, 16'($urandom), 16'($urandom), 1'($urandom));
        while (ov_m !== 1'b1 && n < nmax + 2) begin
            chk("cmp_quiet", {28'd0, ir_m, fl_m}, 32'd0);
            drive(1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom));
            @(posedge clk); #1;
            n++;
        end
        drive(1'b0, 16'($urandom), 16'($urandom), 1'b0);
        chk("latency", 32'(n), 32'(ref_lat(av, bv, w, c)));
        chk("flags", 32'(fl_m), 32'(exp_f));
        chk("in_ready_done", 32'(ir_m), 32'd0);
        for (int h = 0; h < hold; h++) begin
            drive(1'b1, 16'($urandom), 16'($urandom), 1'($urandom));
            @(posedge clk); #1;
            chk("hold_stable", {28'd0, ir_m, fl_m}, {28'd0, 1'b0, exp_f});
            chk("hold_valid", 32'(ov_m), 32'd1);
        end
        drive(1'b0, 16'($urandom), 16'($urandom), 1'b0);
        set_oready(1'b1);
        @(posedge clk); #1;
        set_oready(1'b0);
        chk("after_hs_clear", {28'd0, ov_m, fl_m}, 32'd0);
        chk("after_hs_ready", 32'(ir_m), 32'd1);
    endtask

    initial begin
        logic [15:0] ra, rb;
        logic        rs;
        rst_n = 1'b0;
        iv0 = 0; a0 = '0; b0 = '0; sm0 = 0; or0 = 0;
        iv1 = 0; a1 = '0; b1 = '0; sm1 = 0; or1 = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out0", {26'd0, ir0, ov0, eq0, gt0, lt0}, 32'd0);
        chk("reset_out1", {26'd0, ir1, ov1, eq1, gt1, lt1}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run(1'b0, 16'h1234, 16'h1234, 1'b0, 0);
        run(1'b0, 16'h8000, 16'h7FFF, 1'b0, 0);
        run(1'b0, 16'h1234, 16'h1235, 1'b0, 0);
        run(1'b0, 16'h1334, 16'h1234, 1'b0, 0);
        run(1'b0, 16'hFFFF, 16'h0000, 1'b0, 5);
`ifdef COMPMAG_SIGNED_EN
        run(1'b0, 16'h8000, 16'h7FFF, 1'b1, 0);
        run(1'b0, 16'hFFFF, 16'h0001, 1'b1, 1);
`endif

        // Reset during the second compare cycle must abandon the operation.
        sel = 1'b0;
        drive(1'b1, 16'h1234, 16'h1234, 1'b0);
        @(posedge clk); #1;
        drive(1'b0, 16'h0, 16'h0, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        drive(1'b1, 16'h0001, 16'h0002, 1'b0);
        repeat (2) begin
            @(posedge clk); #1;
            chk("midrst_quiet", {27'd0, ir0, ov0, eq0, gt0, lt0}, 32'd0);
        end
        drive(1'b0, 16'h0, 16'h0, 1'b0);
        rst_n = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            chk("midrst_no_valid", {27'd0, ir0, ov0, eq0, gt0, lt0}, 32'h10);
        end

        for (int i = 0; i < 120; i++) begin
            ra = 16'($urandom);
            case ($urandom_range(0, 2))
                0: rb = ra;
                1: rb = ra ^ (16'h1 << $urandom_range(0, 15));
                default: rb = 16'($urandom);
            endcase
`ifdef COMPMAG_SIGNED_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            run(1'b0, ra, rb, rs, $urandom_range(0, 2));
        end

        run(1'b1, 16'h00, 16'h00, 1'b0, 0);
        run(1'b1, 16'hFF, 16'hFF, 1'b0, 0);
        run(1'b1, 16'h80, 16'h7F, 1'b0, 0);
        run(1'b1, 16'h00, 16'h01, 1'b0, 2);
        run(1'b1, 16'hFE, 16'hFF, 1'b0, 0);
        for (int i = 0; i < 250; i++) begin
            ra = 16'($urandom_range(0, 255));
            rb = ($urandom_range(0, 3) == 0) ? ra : 16'($urandom_range(0, 255));
`ifdef COMPMAG_SIGNED_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            run(1'b1, ra, rb, rs, $urandom_range(0, 1));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
